sb_credit_tracker: RTL and testbench

//  - Parametrised multi-channel credit tracker for the sideband RDI credit loop.
//  - One counter per channel of credits the link partner has advertised.
//  - Consumes one credit per rising edge of the channel valid.
//  - Restores credits on returns; saturates with sticky overflow/underflow errors.
//  - Supports synchronous re-init for link retrain. Feeds per-channel "no credit" back-pressure to the SB RDI tx/rx path.

---
 rtl/sb_credit_tracker.sv | 97 +++++++++
 tb/tb_sb_credit_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sb_credit_tracker.sv
// Multi-channel saturating credit tracker for the sideband RDI credit loop.
// Optional low-watermark output enabled by defining SB_CRD_LOW_WM_EN.
module sb_credit_tracker #(
    parameter  int NUM_CH   = 2,
    parameter  int INIT_CRD = 32,
    parameter  int MAX_CRD  = 32,
    parameter  int LOW_WM   = 4,
    localparam int CNT_W    = $clog2(MAX_CRD + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_crd_reinit,
    input  logic [NUM_CH-1:0]       i_crd_rtn,
    input  logic [NUM_CH-1:0]       i_vld,
    input  logic                    i_err_clr,
    output logic [NUM_CH*CNT_W-1:0] o_crd_cnt,
    output logic [NUM_CH-1:0]       o_no_crd,
    output logic [NUM_CH-1:0]       o_ovf_err,
    output logic [NUM_CH-1:0]       o_unf_err
`ifdef SB_CRD_LOW_WM_EN
    ,
    output logic [NUM_CH-1:0]       o_low_wm
`endif
);

    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_CRD);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CRD);

    // Elaboration-time sanity checks; they generate no hardware.
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("sb_credit_tracker: NUM_CH must be at least 1");
    end
    if (INIT_CRD < 1 || INIT_CRD > MAX_CRD) begin : g_bad_init
        $error("sb_credit_tracker: INIT_CRD must be within 1..MAX_CRD");
    end
    if (LOW_WM < 0) begin : g_bad_low_wm
        $error("sb_credit_tracker: LOW_WM must not be negative");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             vld_q;
        logic             ovf;
        logic             unf;
        logic             rise;
        logic             rtn;
        logic             take;
        logic             at_max;
        logic             ovf_evt;
        logic             unf_evt;

        assign rise    = i_vld[ch] & ~vld_q;
        assign rtn     = i_crd_rtn[ch];
        // A same-cycle return funds the consume, so an empty counter can still take.
        assign take    = rise & ((cnt != '0) | rtn);
        assign at_max  = (cnt == MAX_V);
        assign ovf_evt = rtn & ~take & at_max;
        assign unf_evt = rise & ~take;

        always_comb begin
            cnt_nxt = cnt;
            if (rtn && !take && !at_max) begin
                cnt_nxt = cnt + 1'b1;
            end else if (take && !rtn) begin
                cnt_nxt = cnt - 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                cnt   <= INIT_V;
                vld_q <= 1'b0;
                ovf   <= 1'b0;
                unf   <= 1'b0;
            end else begin
                vld_q <= i_vld[ch];
                cnt   <= i_crd_reinit ? INIT_V : cnt_nxt;
                // Re-init drops events but keeps errors; a new error beats a clear.
                ovf   <= (ovf & ~i_err_clr) | (ovf_evt & ~i_crd_reinit);
                unf   <= (unf & ~i_err_clr) | (unf_evt & ~i_crd_reinit);
            end
        end

        assign o_crd_cnt[ch*CNT_W +: CNT_W] = cnt;
        assign o_no_crd[ch]                 = (cnt == '0);
        assign o_ovf_err[ch]                = ovf;
        assign o_unf_err[ch]                = unf;

`ifdef SB_CRD_LOW_WM_EN
        localparam int LOW_C = (LOW_WM > MAX_CRD) ? MAX_CRD : LOW_WM;
        localparam logic [CNT_W-1:0] LOW_V = CNT_W'(LOW_C);
        assign o_low_wm[ch] = (cnt <= LOW_V);
`endif
    end

endmodule

// File: tb/tb_sb_credit_tracker.sv
// Directed bench for sb_credit_tracker (NUM_CH=2, INIT_CRD=MAX_CRD=32).
// The low-watermark steps run only when SB_CRD_LOW_WM_EN is defined.
module tb_sb_credit_tracker;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 6;

    logic                    i_clk;
    logic                    i_rst_n;
    logic                    i_crd_reinit;
    logic [NUM_CH-1:0]       i_crd_rtn;
    logic [NUM_CH-1:0]       i_vld;
    logic                    i_err_clr;
    logic [NUM_CH*CNT_W-1:0] o_crd_cnt;
    logic [NUM_CH-1:0]       o_no_crd;
    logic [NUM_CH-1:0]       o_ovf_err;
    logic [NUM_CH-1:0]       o_unf_err;
`ifdef SB_CRD_LOW_WM_EN
    logic [NUM_CH-1:0]       o_low_wm;
`endif

    int checks   = 0;
    int failures = 0;

    sb_credit_tracker #(
        .NUM_CH   (2),
        .INIT_CRD (32),
        .MAX_CRD  (32),
        .LOW_WM   (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_crd_reinit (i_crd_reinit),
        .i_crd_rtn    (i_crd_rtn),
        .i_vld        (i_vld),
        .i_err_clr    (i_err_clr),
        .o_crd_cnt    (o_crd_cnt),
        .o_no_crd     (o_no_crd),
        .o_ovf_err    (o_ovf_err),
        .o_unf_err    (o_unf_err)
`ifdef SB_CRD_LOW_WM_EN
        ,
        .o_low_wm     (o_low_wm)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    assign cnt0 = o_crd_cnt[CNT_W-1:0];
    assign cnt1 = o_crd_cnt[2*CNT_W-1:CNT_W];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge per pulse: valid high for a cycle, then low for a cycle.
    task automatic pulse(input logic [NUM_CH-1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            i_vld = mask;
            tick();
            i_vld = '0;
            tick();
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_crd_reinit = 1'b0;
        i_crd_rtn    = '0;
        i_vld        = '0;
        i_err_clr    = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;

        chk("reset_cnt0", 32'(cnt0), 32);
        chk("reset_cnt1", 32'(cnt1), 32);
        chk("reset_no_crd", 32'(o_no_crd), 0);
        chk("reset_ovf", 32'(o_ovf_err), 0);
        chk("reset_unf", 32'(o_unf_err), 0);

        i_vld = 2'b01;
        tick();
        chk("first_take_cnt0", 32'(cnt0), 31);
        i_vld = 2'b00;
        tick();
        pulse(2'b01, 31);
        chk("drain_cnt0", 32'(cnt0), 0);
        chk("drain_no_crd", 32'(o_no_crd), 1);
        chk("drain_cnt1", 32'(cnt1), 32);

        i_vld = 2'b01;
        tick();
        chk("unf_cnt0", 32'(cnt0), 0);
        chk("unf_flag", 32'(o_unf_err), 1);
        i_vld = 2'b00;
        tick();

        pulse(2'b10, 22);
        chk("ch1_at10", 32'(cnt1), 10);
        i_crd_rtn = 2'b10;
        i_vld     = 2'b10;
        tick();
        chk("rtn_rise_10_cnt1", 32'(cnt1), 10);
        chk("rtn_rise_10_ovf", 32'(o_ovf_err), 0);
        chk("rtn_rise_10_unf", 32'(o_unf_err), 1);
        i_crd_rtn = 2'b00;
        i_vld     = 2'b00;
        tick();

        pulse(2'b10, 10);
        chk("ch1_at0", 32'(cnt1), 0);
        chk("both_empty_no_crd", 32'(o_no_crd), 3);
        i_crd_rtn = 2'b10;
        i_vld     = 2'b10;
        tick();
        chk("rtn_rise_0_cnt1", 32'(cnt1), 0);
        chk("rtn_rise_0_unf", 32'(o_unf_err), 1);
        i_crd_rtn = 2'b00;
        i_vld     = 2'b00;
        tick();

        i_crd_rtn = 2'b01;
        repeat (32) tick();
        chk("refill_cnt0", 32'(cnt0), 32);
        chk("refill_no_ovf", 32'(o_ovf_err), 0);
        tick();
        chk("ovf_cnt0", 32'(cnt0), 32);
        chk("ovf_flag", 32'(o_ovf_err), 1);
        i_crd_rtn = 2'b00;

        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr_ovf", 32'(o_ovf_err), 0);
        chk("clr_unf", 32'(o_unf_err), 0);

        i_crd_rtn = 2'b01;
        i_err_clr = 1'b1;
        tick();
        chk("clr_vs_new_ovf", 32'(o_ovf_err), 1);
        i_crd_rtn = 2'b00;
        tick();
        chk("clr_after_ovf", 32'(o_ovf_err), 0);
        i_err_clr = 1'b0;

        i_vld = 2'b01;
        repeat (5) tick();
        i_vld = 2'b00;
        tick();
        chk("held_vld_cnt0", 32'(cnt0), 31);

        pulse(2'b01, 26);
        chk("ch0_at5", 32'(cnt0), 5);
        i_vld = 2'b10;
        tick();
        i_vld = 2'b00;
        chk("ch1_unf_pre_reinit", 32'(o_unf_err), 2);
        i_crd_rtn    = 2'b01;
        i_crd_reinit = 1'b1;
        tick();
        i_crd_rtn    = 2'b00;
        i_crd_reinit = 1'b0;
        chk("reinit_cnt0", 32'(cnt0), 32);
        chk("reinit_cnt1", 32'(cnt1), 32);
        chk("reinit_keeps_unf", 32'(o_unf_err), 2);
        chk("reinit_no_crd", 32'(o_no_crd), 0);

        i_vld   = 2'b01;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk("rst_mid_cnt0", 32'(cnt0), 32);
        chk("rst_mid_unf", 32'(o_unf_err), 0);
        tick();
        chk("rst_held_vld_edge", 32'(cnt0), 31);
        i_vld = 2'b00;
        tick();
        chk("rst_held_vld_once", 32'(cnt0), 31);

`ifdef SB_CRD_LOW_WM_EN
        pulse(2'b01, 26);
        chk("lwm_cnt0_5", 32'(cnt0), 5);
        chk("lwm_off_at5", 32'(o_low_wm), 0);
        i_vld = 2'b01;
        tick();
        chk("lwm_cnt0_4", 32'(cnt0), 4);
        chk("lwm_on_at4", 32'(o_low_wm), 1);
        i_vld = 2'b00;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
